// File: rtl/issue_scoreboard_pkg.sv
// Shared scoreboard constants and helpers: default counter width, GPR count, register index type.
// No logic or latency of its own; imported by the scoreboard top and its counter.
package issue_scoreboard_pkg;

  localparam int SB_CNT_W = 2;
  localparam int SB_NREGS = 32;

  typedef logic [4:0] reg_idx_t;

  // r0 is hard-wired zero, so it never carries a pending write.
  function automatic logic is_tracked(input reg_idx_t r);
    return r != '0;
  endfunction

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Saturating up/down pending counter with clear; simultaneous inc+dec holds the value.
// One-cycle update latency; clr dominates inc/dec; a decrement at zero holds and is flagged.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             max
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && !max) begin
      cnt_d = cnt_q + ONE;
    end else if (dec && !inc && !zero) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
  assign max  = &cnt_q;

  // A lone decrement of an empty counter means the pipeline retired something never issued.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(dec && !inc && !clr && zero));

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-side register scoreboard: gates issue on load-use and counter-full hazards, counts stalls.
// ds_ready_go is combinational from registered counters (no es_allowin path); counter updates land next cycle.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_valid,
  input  logic [4:0]  ds_src1,
  input  logic        ds_src1_used,
  input  logic [4:0]  ds_src2,
  input  logic        ds_src2_used,
  input  logic        ds_gr_we,
  input  logic [4:0]  ds_dest,
  input  logic        ds_is_load,
  input  logic        es_allowin,
  input  logic        ms_ld_done,
  input  logic [4:0]  ms_ld_dest,
  input  logic        ws_retire,
  input  logic [4:0]  ws_dest,
  input  logic        flush,
  output logic        ds_ready_go,
  output logic        ds_fire,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SB_NREGS-1:0][CNT_W-1:0] wr_cnt;
  logic [SB_NREGS-1:0][CNT_W-1:0] ld_cnt;
  logic [SB_NREGS-1:0]            wr_zero;
  logic [SB_NREGS-1:0]            wr_max;
  logic [SB_NREGS-1:0]            ld_zero;
  logic [SB_NREGS-1:0]            ld_max;
  logic                           unused_flags;

  logic        issue_wr;
  logic        src1_haz;
  logic        src2_haz;
  logic        full_haz;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign issue_wr = ds_fire && ds_gr_we && is_tracked(ds_dest);

  assign wr_cnt[0]  = '0;
  assign ld_cnt[0]  = '0;
  assign wr_zero[0] = 1'b1;
  assign wr_max[0]  = 1'b0;
  assign ld_zero[0] = 1'b1;
  assign ld_max[0]  = 1'b0;

  for (genvar r = 1; r < SB_NREGS; r++) begin : g_reg
    logic wr_inc;
    logic wr_dec;
    logic ld_inc;
    logic ld_dec;

    assign wr_inc = issue_wr && (ds_dest == reg_idx_t'(r));
    assign wr_dec = ws_retire && (ws_dest == reg_idx_t'(r));
    assign ld_inc = wr_inc && ds_is_load;
    assign ld_dec = ms_ld_done && (ms_ld_dest == reg_idx_t'(r));

    sb_counter #(.CNT_W(CNT_W)) u_wr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_inc),
      .dec   (wr_dec),
      .clr   (flush),
      .cnt   (wr_cnt[r]),
      .zero  (wr_zero[r]),
      .max   (wr_max[r])
    );

    sb_counter #(.CNT_W(CNT_W)) u_ld (
      .clk   (clk),
      .reset (reset),
      .inc   (ld_inc),
      .dec   (ld_dec),
      .clr   (flush),
      .cnt   (ld_cnt[r]),
      .zero  (ld_zero[r]),
      .max   (ld_max[r])
    );
  end

  // Loads never outnumber writers to the same register, so these flags carry no extra information.
  assign unused_flags = ^{wr_zero, ld_max};

  always_comb begin
    src1_haz = 1'b0;
    src2_haz = 1'b0;
    full_haz = 1'b0;
    // The last outstanding load arriving this cycle is picked up by the memory-stage forward path.
    if (ds_src1_used && is_tracked(ds_src1) && !ld_zero[ds_src1]) begin
      src1_haz = !(ms_ld_done && (ms_ld_dest == ds_src1) && (ld_cnt[ds_src1] == ONE));
    end
    if (ds_src2_used && is_tracked(ds_src2) && !ld_zero[ds_src2]) begin
      src2_haz = !(ms_ld_done && (ms_ld_dest == ds_src2) && (ld_cnt[ds_src2] == ONE));
    end
    if (ds_gr_we && is_tracked(ds_dest) && wr_max[ds_dest]) begin
      full_haz = !(ws_retire && (ws_dest == ds_dest));
    end
  end

  assign ds_ready_go = !(src1_haz || src2_haz || full_haz);
  assign ds_fire     = ds_valid && ds_ready_go && es_allowin;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ds_valid && !ds_ready_go) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed scenarios for issue_scoreboard; expected ready/fire pushed on drive, popped at the sample point.
module tb_issue_scoreboard;

  logic        clk;
  logic        reset;
  logic        ds_valid;
  logic [4:0]  ds_src1;
  logic        ds_src1_used;
  logic [4:0]  ds_src2;
  logic        ds_src2_used;
  logic        ds_gr_we;
  logic [4:0]  ds_dest;
  logic        ds_is_load;
  logic        es_allowin;
  logic        ms_ld_done;
  logic [4:0]  ms_ld_dest;
  logic        ws_retire;
  logic [4:0]  ws_dest;
  logic        flush;
  logic        ds_ready_go;
  logic        ds_fire;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic rdy;
    logic fire;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_fails;

  issue_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .ds_valid     (ds_valid),
    .ds_src1      (ds_src1),
    .ds_src1_used (ds_src1_used),
    .ds_src2      (ds_src2),
    .ds_src2_used (ds_src2_used),
    .ds_gr_we     (ds_gr_we),
    .ds_dest      (ds_dest),
    .ds_is_load   (ds_is_load),
    .es_allowin   (es_allowin),
    .ms_ld_done   (ms_ld_done),
    .ms_ld_dest   (ms_ld_dest),
    .ws_retire    (ws_retire),
    .ws_dest      (ws_dest),
    .flush        (flush),
    .ds_ready_go  (ds_ready_go),
    .ds_fire      (ds_fire),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ds_valid   = 1'b0;
    ms_ld_done = 1'b0;
    ws_retire  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ds_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one decode slot and records the ready/fire the bench expects for it.
  task automatic drive(input logic v, input logic [4:0] s1, input logic u1,
                       input logic [4:0] s2, input logic u2, input logic we,
                       input logic [4:0] d, input logic ld, input logic ai,
                       input logic exp_rdy);
    exp_t x;
    ds_valid     = v;
    ds_src1      = s1;
    ds_src1_used = u1;
    ds_src2      = s2;
    ds_src2_used = u2;
    ds_gr_we     = we;
    ds_dest      = d;
    ds_is_load   = ld;
    es_allowin   = ai;
    x.rdy  = exp_rdy;
    x.fire = v & ai & exp_rdy;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_checks++;
    if ((dut.wr_cnt | dut.ld_cnt) !== '0 || stall_cnt !== 32'd0) begin
      n_fails++;
      $display("FAIL reset_state cnt_or=%h stall=%0d want 0/0", dut.wr_cnt | dut.ld_cnt, stall_cnt);
    end
    reset = 1'b0;
    drive(1, 5'd3, 1, 5'd4, 1, 0, 5'd0, 0, 0, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL reset_noallow rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    es_allowin = 1'b1;
    e.fire = 1'b1;
    #1; n_checks++;
    if (ds_ready_go !== 1'b1 || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL reset_allow rdy/fire=%b/%b want 1/%b", ds_ready_go, ds_fire, e.fire);
    end
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL lu_ld rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd4, 1, 5'd6, 1, 1, 5'd5, 0, 1, 0);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL lu_stall rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd4, 1, 5'd6, 1, 1, 5'd5, 0, 1, 1);
    ms_ld_done = 1'b1; ms_ld_dest = 5'd4;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || stall_cnt !== 32'd1) begin
      n_fails++; $display("FAIL lu_bypass rdy/fire/stall=%b/%b/%0d want %b/%b/1", ds_ready_go, ds_fire, stall_cnt, e.rdy, e.fire);
    end
    step();
    n_checks++;
    if (dut.ld_cnt[4] !== 2'd0 || dut.wr_cnt[4] !== 2'd1 || dut.wr_cnt[5] !== 2'd1) begin
      n_fails++; $display("FAIL lu_counts ld4/wr4/wr5=%0d/%0d/%0d want 0/1/1", dut.ld_cnt[4], dut.wr_cnt[4], dut.wr_cnt[5]);
    end
    // Second source: unused read must not stall, used read must.
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd8, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd8, 0, 5'd8, 0, 0, 5'd0, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL lu_unused rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd0, 0, 5'd8, 1, 0, 5'd0, 0, 1, 0);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL lu_src2 rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd0, 0, 5'd8, 1, 0, 5'd0, 0, 1, 1);
    ms_ld_done = 1'b1; ms_ld_dest = 5'd8;
    @(negedge clk); e = exp_q.pop_front(); step();
    // Two loads outstanding: the first load's data alone does not release the reader.
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd10, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    ms_ld_done = 1'b1; ms_ld_dest = 5'd10;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL lu_ld_cnt2 rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    ms_ld_done = 1'b1; ms_ld_dest = 5'd10;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || stall_cnt !== 32'd3) begin
      n_fails++; $display("FAIL lu_ld_cnt1 rdy/fire/stall=%b/%b/%0d want %b/%b/3", ds_ready_go, ds_fire, stall_cnt, e.rdy, e.fire);
    end
    step();
  endtask

  task automatic test_alu_dep();
    do_reset();
    drive(1, 5'd1, 1, 5'd0, 0, 1, 5'd4, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd4, 1, 5'd4, 1, 1, 5'd5, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || dut.wr_cnt[4] !== 2'd1) begin
      n_fails++; $display("FAIL alu_dep rdy/fire/wr4=%b/%b/%0d want %b/%b/1", ds_ready_go, ds_fire, dut.wr_cnt[4], e.rdy, e.fire);
    end
    step();
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd7, 0, 1, 1);
    ws_retire = 1'b1; ws_dest = 5'd7;
    @(negedge clk); e = exp_q.pop_front(); step();
    n_checks++;
    if (dut.wr_cnt[7] !== 2'd1) begin
      n_fails++; $display("FAIL same_inc_dec wr7=%0d want 1", dut.wr_cnt[7]);
    end
    drive(1, 5'd7, 1, 5'd0, 0, 1, 5'd7, 1, 1, 1);
    ws_retire = 1'b1; ws_dest = 5'd7;
    ms_ld_done = 1'b1; ms_ld_dest = 5'd7;
    @(negedge clk); e = exp_q.pop_front(); step();
    n_checks++;
    if (dut.wr_cnt[7] !== 2'd1 || dut.ld_cnt[7] !== 2'd0) begin
      n_fails++; $display("FAIL same_all4 wr7/ld7=%0d/%0d want 1/0", dut.wr_cnt[7], dut.ld_cnt[7]);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 1, 1);
      @(negedge clk); e = exp_q.pop_front(); step();
    end
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 1, 0);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || dut.wr_cnt[9] !== 2'd3) begin
      n_fails++; $display("FAIL full_block rdy/fire/wr9=%b/%b/%0d want %b/%b/3", ds_ready_go, ds_fire, dut.wr_cnt[9], e.rdy, e.fire);
    end
    step();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd9, 0, 1, 1);
    ws_retire = 1'b1; ws_dest = 5'd9;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL full_release rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    n_checks++;
    if (dut.wr_cnt[9] !== 2'd3 || stall_cnt !== 32'd1) begin
      n_fails++; $display("FAIL full_after wr9/stall=%0d/%0d want 3/1", dut.wr_cnt[9], stall_cnt);
    end
  endtask

  task automatic test_r0_flush();
    do_reset();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd0, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd0, 1, 5'd0, 1, 0, 5'd0, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || (dut.wr_cnt | dut.ld_cnt) !== '0) begin
      n_fails++; $display("FAIL r0_ignore rdy/fire=%b/%b want %b/%b cnt_or=%h want 0", ds_ready_go, ds_fire, e.rdy, e.fire, dut.wr_cnt | dut.ld_cnt);
    end
    step();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd3, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
    flush = 1'b1; ws_retire = 1'b1; ws_dest = 5'd3;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire) begin
      n_fails++; $display("FAIL flush_cycle rdy/fire=%b/%b want %b/%b", ds_ready_go, ds_fire, e.rdy, e.fire);
    end
    step();
    drive(1, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || (dut.wr_cnt | dut.ld_cnt) !== '0 || stall_cnt !== 32'd2) begin
      n_fails++; $display("FAIL flush_after rdy/fire/stall=%b/%b/%0d want %b/%b/2 cnt_or=%h want 0", ds_ready_go, ds_fire, stall_cnt, e.rdy, e.fire, dut.wr_cnt | dut.ld_cnt);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1, 5'd0, 0, 5'd0, 0, 1, 5'd4, 1, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd4, 1, 5'd0, 0, 1, 5'd6, 0, 1, 0);
    @(negedge clk); e = exp_q.pop_front(); step();
    drive(1, 5'd4, 1, 5'd0, 0, 1, 5'd6, 0, 1, 0);
    reset = 1'b1;
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || stall_cnt !== 32'd3) begin
      n_fails++; $display("FAIL rst_mid_before rdy/stall=%b/%0d want %b/3", ds_ready_go, stall_cnt, e.rdy);
    end
    step();
    reset = 1'b0;
    drive(1, 5'd4, 1, 5'd0, 0, 1, 5'd6, 0, 1, 1);
    @(negedge clk); e = exp_q.pop_front(); n_checks++;
    if (ds_ready_go !== e.rdy || ds_fire !== e.fire || stall_cnt !== 32'd0 || (dut.wr_cnt | dut.ld_cnt) !== '0) begin
      n_fails++; $display("FAIL rst_mid_after rdy/fire/stall=%b/%b/%0d want %b/%b/0 cnt_or=%h want 0", ds_ready_go, ds_fire, stall_cnt, e.rdy, e.fire, dut.wr_cnt | dut.ld_cnt);
    end
    step();
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    ds_valid     = 1'b0;
    ds_src1      = '0;
    ds_src1_used = 1'b0;
    ds_src2      = '0;
    ds_src2_used = 1'b0;
    ds_gr_we     = 1'b0;
    ds_dest      = '0;
    ds_is_load   = 1'b0;
    es_allowin   = 1'b0;
    ms_ld_done   = 1'b0;
    ms_ld_dest   = '0;
    ws_retire    = 1'b0;
    ws_dest      = '0;
    flush        = 1'b0;
    n_checks     = 0;
    n_fails      = 0;
    test_reset();
    test_load_use();
    test_alu_dep();
    test_same_cycle();
    test_full();
    test_r0_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register scoreboard and issue scheduler for the 5-stage LoongArch pipeline, sitting beside the decode stage. It tracks every in-flight register write between decode and write-back, and counts in-flight loads separately. It decides each cycle whether the instruction held in decode may issue to execute; this replaces ad-hoc load-use comparisons with a single stall source. It also flushes all tracking state on request and keeps a stall-cycle statistic.

## Interface
- `CNT_W`, default 2: width of each per-register pending counter. Maximum in-flight writers per register is 2^CNT_W-1.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high. Clears all state.
- `ds_valid` in 1: decode holds a valid instruction.
- `ds_src1` in 5: rj read address.
- `ds_src1_used` in 1: rj is actually read.
- `ds_src2` in 5: rk/rd read address.
- `ds_src2_used` in 1: second source is actually read.
- `ds_gr_we` in 1: the decoded instruction writes a GPR.
- `ds_dest` in 5: destination register.
- `ds_is_load` in 1: the decoded instruction is ld.w.
- `es_allowin` in 1: execute can accept.
- `ms_ld_done` in 1: a load's data is available at the memory stage this cycle.
- `ms_ld_dest` in 5: destination of that load.
- `ws_retire` in 1: write-back writes the regfile this cycle.
- `ws_dest` in 5: write-back address.
- `flush` in 1: discard all in-flight tracking.
- `ds_ready_go` out 1: decode may issue.
- `ds_fire` out 1: `ds_valid & ds_ready_go & es_allowin`.
- `stall_cnt` out 32: number of cycles with `ds_valid & !ds_ready_go`.

## Operation
- State per register r1..r31:
  - `wr_cnt[r]` (CNT_W bits): writers issued but not yet retired.
  - `ld_cnt[r]` (CNT_W bits): loads issued whose data is not yet produced.
- r0 is never tracked. Both counters for r0 read as 0, and any event addressed to r0 is ignored.
- Load hazard on a source s: `s_used & s!=0 & ld_cnt[s]!=0`. It is not counted as a hazard when `ms_ld_done & ms_ld_dest==s & ld_cnt[s]==1` (same-cycle bypass, which matches the memory-stage forward).
- Full hazard: `ds_gr_we & ds_dest!=0 & wr_cnt[ds_dest]==max`, unless `ws_retire & ws_dest==ds_dest` in the same cycle.
- `ds_ready_go = !(src1 load hazard | src2 load hazard | full hazard)`.
- Non-load write hazards do not stall; the forward buses resolve them.
- On `ds_fire & ds_gr_we & ds_dest!=0`:
  - `wr_cnt[ds_dest]` increments.
  - If `ds_is_load`, `ld_cnt[ds_dest]` also increments.
- `ms_ld_done` decrements `ld_cnt[ms_ld_dest]`. `ws_retire` decrements `wr_cnt[ws_dest]`.
- Simultaneous increment and decrement on the same counter leaves it unchanged. All four events may hit the same register in one cycle.
- A decrement at 0 is a protocol error: the counter holds at 0, and a simulation-only assertion fires.
- `flush` zeroes all counters on the next edge and ignores every other event that cycle. `ds_ready_go` is unaffected in the flush cycle.
- `stall_cnt` wraps at 2^32 and is not cleared by `flush`.

## Timing
- `ds_ready_go` and `ds_fire` are combinational from the inputs and registered counters. There is no combinational path from `es_allowin` to `ds_ready_go`.
- Counter updates are visible to the hazard logic one cycle after the event edge.
- Load-use penalty: a dependent instruction directly behind an ld.w stalls exactly 1 cycle, until the load's `ms_ld_done` cycle.
- Reset values: all counters 0; `stall_cnt` 0; `ds_ready_go` 1 in the first cycle after reset; `ds_fire` equals `ds_valid & es_allowin`.
- Reset asserted mid-operation wins over `flush` and all events.

## Structure
- Shared `mycpu.h` gains `SB_CNT_W`, replacing the `CNT_W` default, and the register-count constant 32.
- One natural sub-module, `sb_counter`: a CNT_W up/down counter with inc, dec, clr, and zero/max flags. It is instantiated 62 times (31 registers × 2 counters) via generate.
- The hazard/ready logic stays in the top module.

## Test plan
- Load-use stall:
  - Stimulus: fire ld.w r4, then next cycle add r5,r4,r6 with src1_used.
  - Required: `ds_ready_go`=0 for 1 cycle, 1 in the cycle `ms_ld_done`(r4) rises; `stall_cnt`=1.
- No stall on an ALU dependency:
  - Stimulus: addi r4 followed by add r5,r4,r4.
  - Required: `ds_ready_go` stays 1 and `wr_cnt[r4]`=1 after issue.
- Same-cycle events:
  - Stimulus: on one edge, fire with dest r7 and `ws_retire` r7, with `wr_cnt[r7]`=1.
  - Required: `wr_cnt[r7]` stays 1.
- Counter full (CNT_W=2):
  - Stimulus: three writers to r9 with no retire, then a fourth.
  - Required: `ds_ready_go`=0. Asserting `ws_retire` r9 in that cycle releases it.
- r0 and flush:
  - Stimulus: ld.w r0, then a reader of r0.
  - Required: no stall and r0 counters remain 0.
  - Stimulus: `flush` with r3 `ld_cnt`=1.
  - Required: all counters are 0 next cycle and a reader of r3 issues; `stall_cnt` is retained.
- Reset mid-stall:
  - Stimulus: assert `reset` during a load-use stall.
  - Required: counters and `stall_cnt`=0 next cycle and `ds_ready_go`=1.
